// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM encoding and the hard-wired zero register.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    DIV_WAIT    = 2'd1,
    DIV_RELEASE = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_stall_counter.sv
// 32-bit saturating event counter; increments on enabled edges and sticks at all-ones.
module pipe_stall_counter (
  input  logic        clock,
  input  logic        resetn,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard control: load-use stalls, multi-cycle divide freeze and taken-branch flush.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_is_div,
  input  logic        id_branch_taken,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rn,
  output logic        wpcir,
  output logic        bubble,
  output logic        flush_if,
  output logic        div_start,
  output logic        div_busy,
  output logic [31:0] stall_cycles
);

  hz_state_t  state;
  logic [7:0] div_cnt;
  logic       load_use;

  assign load_use = ex_wreg & ex_m2reg & (ex_rn != REG_ZERO) &
                    ((id_use_rs & (ex_rn == id_rs)) | (id_use_rt & (ex_rn == id_rt)));

  // Outputs decode state plus live inputs; reset overrides so they settle at once.
  always_comb begin
    wpcir     = 1'b1;
    bubble    = 1'b0;
    div_start = 1'b0;
    div_busy  = 1'b0;
    if (resetn) begin
      unique case (state)
        RUN: begin
          if (load_use) begin
            wpcir  = 1'b0;
            bubble = 1'b1;
          end else if (id_is_div) begin
            div_start = 1'b1;
            wpcir     = 1'b0;
            bubble    = 1'b1;
          end
        end
        DIV_WAIT: begin
          wpcir    = 1'b0;
          bubble   = 1'b1;
          div_busy = 1'b1;
        end
        DIV_RELEASE: ;
        default: ;
      endcase
    end
  end

  assign flush_if = id_branch_taken & wpcir;

  // The counter reaches zero on the edge that enters DIV_RELEASE, giving
  // DIV_CYCLES-1 wait cycles after the start cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= RUN;
      div_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (!load_use && id_is_div) begin
            div_cnt <= 8'(DIV_CYCLES - 1);
            state   <= DIV_WAIT;
          end
        end
        DIV_WAIT: begin
          div_cnt <= div_cnt - 8'd1;
          if (div_cnt == 8'd1) begin
            state <= DIV_RELEASE;
          end
        end
        DIV_RELEASE: state <= RUN;
        default:     state <= RUN;
      endcase
    end
  end

  pipe_stall_counter u_stall_cnt (
    .clock  (clock),
    .resetn (resetn),
    .en     (~wpcir),
    .count  (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with a 4-cycle divide.
module tb_pipe_hazard_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic [4:0]  id_rs, id_rt, ex_rn;
  logic        id_use_rs, id_use_rt, id_is_div, id_branch_taken;
  logic        ex_wreg, ex_m2reg;
  logic        wpcir, bubble, flush_if, div_start, div_busy;
  logic [31:0] stall_cycles;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] exp_stall;

  pipe_hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_is_div       (id_is_div),
    .id_branch_taken (id_branch_taken),
    .ex_wreg         (ex_wreg),
    .ex_m2reg        (ex_m2reg),
    .ex_rn           (ex_rn),
    .wpcir           (wpcir),
    .bubble          (bubble),
    .flush_if        (flush_if),
    .div_start       (div_start),
    .div_busy        (div_busy),
    .stall_cycles    (stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rn = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_is_div = 1'b0; id_branch_taken = 1'b0;
    ex_wreg = 1'b0; ex_m2reg = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic w, input logic b, input logic f,
                           input logic s, input logic busy);
    check_eq({tag, ".wpcir"},     {31'd0, wpcir},     {31'd0, w});
    check_eq({tag, ".bubble"},    {31'd0, bubble},    {31'd0, b});
    check_eq({tag, ".flush_if"},  {31'd0, flush_if},  {31'd0, f});
    check_eq({tag, ".div_start"}, {31'd0, div_start}, {31'd0, s});
    check_eq({tag, ".div_busy"},  {31'd0, div_busy},  {31'd0, busy});
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    #2;
    check_ctl("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset.stall", stall_cycles, 32'd0);
    id_branch_taken = 1'b1;
    id_is_div = 1'b1;
    #1;
    check_ctl("reset_br", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    clear_inputs();
    @(negedge clock);
    resetn = 1'b1;
    tick();
    exp_stall = 32'd0;

    // Load-use on rs, with a taken branch that must not flush
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    id_branch_taken = 1'b1;
    #1;
    check_ctl("lu_rs", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("lu_rs.stall", stall_cycles, exp_stall);
    tick();
    exp_stall = 32'd1;
    clear_inputs();
    #1;
    check_ctl("lu_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("lu_after.stall", stall_cycles, exp_stall);

    // r0 never creates a hazard
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #1;
    check_ctl("r0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // rt matches but is not read
    ex_rn = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_use_rs = 1'b1; id_use_rt = 1'b0;
    #1;
    check_ctl("rt_unused", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // non-load writer does not stall
    id_use_rt = 1'b1; ex_m2reg = 1'b0;
    #1;
    check_ctl("alu_fwd", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // rt read: stall, and load-use wins over divide start
    ex_m2reg = 1'b1; id_is_div = 1'b1;
    #1;
    check_ctl("lu_rt", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    exp_stall = 32'd2;
    clear_inputs();
    #1;
    check_eq("lu_rt.stall", stall_cycles, exp_stall);

    // Taken branch in RUN flushes
    id_branch_taken = 1'b1;
    #1;
    check_ctl("br_run", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    clear_inputs();

    // Divide with id_is_div held: 1 start + 3 wait + 1 release
    id_is_div = 1'b1;
    #1;
    check_ctl("div0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_stall = exp_stall + 32'd1;
      id_branch_taken = (k == 2);
      #1;
      check_ctl($sformatf("div_wait%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check_eq($sformatf("div_wait%0d.stall", k), stall_cycles, exp_stall);
    end
    tick();
    exp_stall = exp_stall + 32'd1;
    id_branch_taken = 1'b1;
    #1;
    check_ctl("div_release", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("div_release.stall", stall_cycles, exp_stall);
    tick();
    clear_inputs();
    #1;
    check_ctl("div_done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("div_done.stall", stall_cycles, 32'd6);

    // Reset in the second wait cycle abandons the divide
    id_is_div = 1'b1;
    tick();
    id_is_div = 1'b0;
    tick();
    #1;
    check_eq("pre_rst.busy", {31'd0, div_busy}, 32'd1);
    id_is_div = 1'b1;
    resetn = 1'b0;
    #1;
    check_ctl("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("mid_rst.stall", stall_cycles, 32'd0);
    id_is_div = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    tick();
    id_is_div = 1'b1;
    #1;
    check_ctl("post_rst_div", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    clear_inputs();
    resetn = 1'b0;
    #1;
    resetn = 1'b1;

    // Saturation of the stall counter
    @(negedge clock);
    force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count;
    #1;
    check_eq("sat.preload", stall_cycles, 32'hFFFF_FFFE);
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq($sformatf("sat%0d", k), stall_cycles, 32'hFFFF_FFFF);
    end
    clear_inputs();
    tick();
    check_eq("sat.hold", stall_cycles, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
